// File: rtl/nmea_sentence_tx.sv
// NMEA-0183 sentence builder and 8N1 UART transmitter.
// A frame FSM fills a one-byte holding register while the serialiser shifts the previous char.
module nmea_sentence_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned MAX_DATA     = 70
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [15:0] i_talker,
    input  logic [23:0] i_sentence,
    input  logic [7:0]  i_data,
    input  logic        i_data_valid,
    input  logic        i_data_last,
    output logic        o_data_ready,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_trunc,
    output logic [7:0]  o_checksum,
    output logic [7:0]  o_fieldcnt
);

    localparam int unsigned CKW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned DCW = $clog2(MAX_DATA + 1);
    localparam logic [CKW-1:0] CLK_LAST  = CKW'(CLKS_PER_BIT - 1);
    localparam logic [DCW-1:0] DATA_LAST = DCW'(MAX_DATA - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_TI0, S_TI1, S_SI0, S_SI1, S_SI2, S_COMMA, S_DATA,
        S_STAR, S_CKHI, S_CKLO, S_CR, S_LF, S_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    talker_q, talker_d;
    logic [23:0]    sent_q, sent_d;
    logic [7:0]     hold_q, hold_d;
    logic           hold_full_q, hold_full_d;
    logic [7:0]     cks_q, cks_d;
    logic [7:0]     fcnt_q, fcnt_d;
    logic           trunc_q, trunc_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [DCW-1:0] dcnt_q, dcnt_d;
    logic [9:0]     shift_q, shift_d;
    logic           ser_on_q, ser_on_d;
    logic [3:0]     bit_q, bit_d;
    logic [CKW-1:0] clk_q, clk_d;

    logic           bit_end, stop_end, take;
    logic           ld_en, ld_ck;
    logic [7:0]     ld_char;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    assign bit_end  = ser_on_q && (clk_q == CLK_LAST);
    assign stop_end = bit_end && (bit_q == 4'd9);

    always_comb begin
        state_d     = state_q;
        talker_d    = talker_q;
        sent_d      = sent_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cks_d       = cks_q;
        fcnt_d      = fcnt_q;
        trunc_d     = trunc_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dcnt_d      = dcnt_q;
        shift_d     = shift_q;
        ser_on_d    = ser_on_q;
        bit_d       = bit_q;
        clk_d       = clk_q;
        take        = 1'b0;
        ld_en       = 1'b0;
        ld_ck       = 1'b0;
        ld_char     = '0;

        // Serialiser: a full holding register is taken at the stop-bit boundary with no gap
        if (ser_on_q) begin
            if (bit_end) begin
                clk_d = '0;
                if (bit_q == 4'd9) begin
                    if (hold_full_q) take = 1'b1;
                    else             ser_on_d = 1'b0;
                end else begin
                    bit_d   = bit_q + 4'd1;
                    shift_d = {1'b1, shift_q[9:1]};
                end
            end else begin
                clk_d = clk_q + CKW'(1);
            end
        end else if (hold_full_q) begin
            take = 1'b1;
        end

        if (take) begin
            shift_d     = {1'b1, hold_q, 1'b0};
            bit_d       = '0;
            clk_d       = '0;
            ser_on_d    = 1'b1;
            hold_full_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    // '$' bypasses the holding register so its start bit is on the line next cycle
                    talker_d = i_talker;
                    sent_d   = i_sentence;
                    cks_d    = '0;
                    fcnt_d   = '0;
                    trunc_d  = 1'b0;
                    dcnt_d   = '0;
                    busy_d   = 1'b1;
                    shift_d  = {1'b1, 8'h24, 1'b0};
                    bit_d    = '0;
                    clk_d    = '0;
                    ser_on_d = 1'b1;
                    state_d  = S_TI0;
                end
            end
            S_TI0: if (!hold_full_q) begin
                ld_en = 1'b1; ld_ck = 1'b1; ld_char = talker_q[7:0];  state_d = S_TI1;
            end
            S_TI1: if (!hold_full_q) begin
                ld_en = 1'b1; ld_ck = 1'b1; ld_char = talker_q[15:8]; state_d = S_SI0;
            end
            S_SI0: if (!hold_full_q) begin
                ld_en = 1'b1; ld_ck = 1'b1; ld_char = sent_q[7:0];    state_d = S_SI1;
            end
            S_SI1: if (!hold_full_q) begin
                ld_en = 1'b1; ld_ck = 1'b1; ld_char = sent_q[15:8];   state_d = S_SI2;
            end
            S_SI2: if (!hold_full_q) begin
                ld_en = 1'b1; ld_ck = 1'b1; ld_char = sent_q[23:16];  state_d = S_COMMA;
            end
            S_COMMA: if (!hold_full_q) begin
                ld_en = 1'b1; ld_ck = 1'b1; ld_char = 8'h2C;          state_d = S_DATA;
            end
            S_DATA: if (!hold_full_q && i_data_valid) begin
                ld_en   = 1'b1;
                ld_ck   = 1'b1;
                ld_char = i_data;
                dcnt_d  = dcnt_q + DCW'(1);
                if (i_data_last || (dcnt_q == DATA_LAST)) begin
                    trunc_d = !i_data_last;
                    state_d = S_STAR;
                end
            end
            S_STAR: if (!hold_full_q) begin
                ld_en = 1'b1; ld_char = 8'h2A;                  state_d = S_CKHI;
            end
            S_CKHI: if (!hold_full_q) begin
                ld_en = 1'b1; ld_char = hex_ascii(cks_q[7:4]);  state_d = S_CKLO;
            end
            S_CKLO: if (!hold_full_q) begin
                ld_en = 1'b1; ld_char = hex_ascii(cks_q[3:0]);  state_d = S_CR;
            end
            S_CR: if (!hold_full_q) begin
                ld_en = 1'b1; ld_char = 8'h0D;                  state_d = S_LF;
            end
            S_LF: if (!hold_full_q) begin
                ld_en = 1'b1; ld_char = 8'h0A;                  state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (stop_end && !hold_full_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (ld_en) begin
            hold_d      = ld_char;
            hold_full_d = 1'b1;
            if (ld_ck)            cks_d  = cks_q ^ ld_char;
            if (ld_char == 8'h2C) fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= S_IDLE;
            talker_q    <= '0;
            sent_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cks_q       <= '0;
            fcnt_q      <= '0;
            trunc_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dcnt_q      <= '0;
            shift_q     <= '1;
            ser_on_q    <= 1'b0;
            bit_q       <= '0;
            clk_q       <= '0;
        end else begin
            state_q     <= state_d;
            talker_q    <= talker_d;
            sent_q      <= sent_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cks_q       <= cks_d;
            fcnt_q      <= fcnt_d;
            trunc_q     <= trunc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dcnt_q      <= dcnt_d;
            shift_q     <= shift_d;
            ser_on_q    <= ser_on_d;
            bit_q       <= bit_d;
            clk_q       <= clk_d;
        end
    end

    assign o_tx         = ser_on_q ? shift_q[0] : 1'b1;
    assign o_data_ready = (state_q == S_DATA) && !hold_full_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_trunc      = trunc_q;
    assign o_checksum   = cks_q;
    assign o_fieldcnt   = fcnt_q;

endmodule

// File: tb/tb_nmea_sentence_tx.sv
// Bench for nmea_sentence_tx: decodes the UART line and checks sentences, flags and timing.
module tb_nmea_sentence_tx;

    localparam int CPB  = 4;
    localparam int MAXD = 4;
    localparam int LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [15:0] i_talker;
    logic [23:0] i_sentence;
    logic [7:0]  i_data;
    logic        i_data_valid;
    logic        i_data_last;
    logic        o_data_ready, o_tx, o_busy, o_done, o_trunc;
    logic [7:0]  o_checksum, o_fieldcnt;

    nmea_sentence_tx #(.CLKS_PER_BIT(CPB), .MAX_DATA(MAXD)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(i_start), .i_talker(i_talker),
        .i_sentence(i_sentence), .i_data(i_data), .i_data_valid(i_data_valid),
        .i_data_last(i_data_last), .o_data_ready(o_data_ready), .o_tx(o_tx),
        .o_busy(o_busy), .o_done(o_done), .o_trunc(o_trunc),
        .o_checksum(o_checksum), .o_fieldcnt(o_fieldcnt)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_pass   = 0;
    byte   rx_q[$];
    string HEXD = "0123456789ABCDEF";

    typedef struct {
        string tk; string sid; string pay; bit last; int stall; bit pulse; bit chain;
        string exp; logic [7:0] ck; int fc; bit tr; int n;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic string pr(input string s);
        string r = "";
        for (int k = 0; k < s.len(); k++)
            r = {r, (s[k] < 8'h20) ? "~" : s.substr(k, k)};
        return r;
    endfunction

    task automatic chk_str(input string name, input string act, input string exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got \"%s\", expected \"%s\"", name, pr(act), pr(exp));
    endtask

    // Reference: build the sentence text directly from the framing rules
    function automatic void model(input string tk, input string sid, input string pay,
                                  input bit use_last, output string s, output logic [7:0] ck,
                                  output int fc, output bit tr, output int n);
        string body;
        if (!use_last || pay.len() > MAXD) begin n = MAXD; tr = 1'b1; end
        else begin n = pay.len(); tr = 1'b0; end
        body = {tk, sid, ",", pay.substr(0, n - 1)};
        ck = 8'h00; fc = 0;
        for (int k = 0; k < body.len(); k++) begin
            ck ^= body[k];
            if (body[k] == 8'h2C) fc++;
        end
        s = {"$", body, "*", HEXD.substr(int'(ck[7:4]), int'(ck[7:4])),
             HEXD.substr(int'(ck[3:0]), int'(ck[3:0])), "\015\012"};
    endfunction

    // UART decoder: mid-bit sampling on the falling clock edge; bytes cut by reset are dropped
    initial begin
        logic [7:0] b;
        bit good, hit_rst;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && o_tx === 1'b0) begin
                good = 1'b1; hit_rst = 1'b0; b = '0;
                repeat (2) @(negedge clk);
                if (!rst_n) hit_rst = 1'b1;
                if (o_tx !== 1'b0) good = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = o_tx;
                    if (!rst_n) hit_rst = 1'b1;
                end
                repeat (CPB) @(negedge clk);
                if (!rst_n) hit_rst = 1'b1;
                if (o_tx !== 1'b1) good = 1'b0;
                if (!hit_rst) rx_q.push_back(good ? b : 8'h7E);
                @(negedge clk);
            end
        end
    end

    // Issues i_start in the current cycle and runs the frame up to (and returning in) the o_done cycle
    task automatic run_frame(input string tag, input string tk, input string sid, input string pay,
                             input bit use_last, input int stall_at, input bit pulse_ck,
                             input string exp, input logic [7:0] exp_ck, input int exp_fc,
                             input bit exp_tr, input int exp_n);
        int idx = 0, acc = 0, cyc, busy = 0, gap = 0, late_ready = 0;
        bit done = 1'b0, gap_ok = 1'b1, busy_at_done = 1'b1;
        logic [7:0] ck = '0, fc = '0;
        bit tr = 1'b0;
        string got = "";
        rx_q.delete();
        i_talker   = {tk[1], tk[0]};
        i_sentence = {sid[2], sid[1], sid[0]};
        i_start    = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cyc = 1;
        chk({tag, ".first_cycle"}, {o_tx, o_busy, o_done, o_trunc, o_checksum, o_fieldcnt},
            {1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00});
        if (o_busy) busy++;
        while (!done && cyc < LIMIT) begin
            i_start = pulse_ck && (cyc == 40 * (8 + exp_n) + 20);
            if (idx < pay.len() && !(idx == stall_at && gap < 50)) begin
                i_data_valid = 1'b1;
                i_data       = pay[idx];
                i_data_last  = use_last && (idx == pay.len() - 1);
            end else begin
                i_data_valid = 1'b0;
                i_data_last  = 1'b0;
                if (idx == stall_at && gap < 50 && o_data_ready) begin
                    if (gap >= 40 && o_tx !== 1'b1) gap_ok = 1'b0;
                    gap++;
                end
            end
            if (o_data_ready && acc >= exp_n) late_ready++;
            if (o_data_ready && i_data_valid) begin idx++; acc++; end
            @(negedge clk);
            cyc++;
            if (o_busy) busy++;
            if (o_done) begin
                done = 1'b1; busy_at_done = o_busy;
                ck = o_checksum; fc = o_fieldcnt; tr = o_trunc;
            end
        end
        i_start = 1'b0; i_data_valid = 1'b0; i_data_last = 1'b0;
        foreach (rx_q[k]) got = {got, $sformatf("%c", rx_q[k])};
        chk({tag, ".done_seen"}, done, 1);
        chk_str({tag, ".line"}, got, exp);
        chk({tag, ".checksum"}, ck, exp_ck);
        chk({tag, ".fieldcnt"}, fc, exp_fc);
        chk({tag, ".trunc"}, tr, exp_tr);
        chk({tag, ".accepted"}, acc, exp_n);
        chk({tag, ".late_ready"}, late_ready, 0);
        chk({tag, ".busy_at_done"}, busy_at_done, 0);
        if (stall_at < 0) chk({tag, ".busy_cycles"}, busy, 10 * CPB * (exp_n + 12));
        else              chk({tag, ".gap_idle"}, {gap_ok, 8'(gap)}, {1'b1, 8'd50});
    endtask

    vec_t vecs[6];
    bit   prev_tr;

    initial begin
        string cs = "0123456789ABCDEFGHIJ,.-";
        rst_n = 1'b0; i_start = 1'b0; i_talker = '0; i_sentence = '0;
        i_data = '0; i_data_valid = 1'b0; i_data_last = 1'b0;

        vecs[0] = '{"GP", "GGA", "1,2",     1'b1, -1, 1'b0, 1'b0, "$GPGGA,1,2*55\015\012",  8'h55, 2, 1'b0, 3};
        vecs[1] = '{"GP", "RMC", "Z",       1'b1, -1, 1'b1, 1'b1, "$GPRMC,Z*3D\015\012",    8'h3D, 1, 1'b0, 1};
        vecs[2] = '{"GP", "GGA", "1,2",     1'b1,  2, 1'b0, 1'b0, "$GPGGA,1,2*55\015\012",  8'h55, 2, 1'b0, 3};
        vecs[3] = '{"GP", "GGA", "ABCDEFG", 1'b0, -1, 1'b0, 1'b0, "$GPGGA,ABCD*7E\015\012", 8'h7E, 1, 1'b1, 4};
        vecs[4] = '{"GP", "GGA", "AB,D",    1'b1, -1, 1'b0, 1'b0, "$GPGGA,AB,D*11\015\012", 8'h11, 2, 1'b0, 4};
        vecs[5] = '{"II", "XDR", ",",       1'b1, -1, 1'b0, 1'b1, "$IIXDR,,*4E\015\012",    8'h4E, 2, 1'b0, 1};

        repeat (3) @(negedge clk);
        chk("reset_state", {o_tx, o_busy, o_done, o_data_ready, o_trunc, o_checksum, o_fieldcnt},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        prev_tr = 1'b0;
        foreach (vecs[v]) begin
            if (!vecs[v].chain) begin
                repeat (20) @(negedge clk);
                chk($sformatf("vec%0d.idle", v), {o_busy, o_tx, o_trunc}, {1'b0, 1'b1, prev_tr});
            end
            run_frame($sformatf("vec%0d", v), vecs[v].tk, vecs[v].sid, vecs[v].pay, vecs[v].last,
                      vecs[v].stall, vecs[v].pulse, vecs[v].exp, vecs[v].ck, vecs[v].fc,
                      vecs[v].tr, vecs[v].n);
            prev_tr = vecs[v].tr;
        end

        // Reset during the sentence-ID chars while the line is low
        begin
            int cyc;
            repeat (20) @(negedge clk);
            i_talker = {"P", "G"}; i_sentence = {"A", "G", "G"}; i_start = 1'b1;
            @(negedge clk);
            i_start = 1'b0; cyc = 1;
            while (!(cyc >= 121 && o_tx == 1'b0) && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            chk("rst.window", cyc < 200, 1);
            #2 rst_n = 1'b0;
            #1 chk("rst.immediate", {o_tx, o_busy, o_done, o_data_ready, o_trunc, o_checksum, o_fieldcnt},
                   {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (60) @(negedge clk);
            chk("rst.idle", {o_tx, o_busy}, {1'b1, 1'b0});
            run_frame("post_rst", "GP", "GGA", "1,2", 1'b1, -1, 1'b0,
                      "$GPGGA,1,2*55\015\012", 8'h55, 2, 1'b0, 3);
        end

        // Randomized sentences against the reference model
        for (int r = 0; r < 6; r++) begin
            string tk, sid, pay, exp;
            logic [7:0] eck;
            int efc, en, len, stall;
            bit etr, ul;
            tk  = $sformatf("%c%c", 8'(8'h41 + $urandom_range(0, 25)), 8'(8'h41 + $urandom_range(0, 25)));
            sid = $sformatf("%c%c%c", 8'(8'h41 + $urandom_range(0, 25)),
                            8'(8'h41 + $urandom_range(0, 25)), 8'(8'h41 + $urandom_range(0, 25)));
            ul  = 1'($urandom_range(0, 1));
            len = ul ? int'($urandom_range(1, MAXD + 2)) : int'($urandom_range(MAXD, MAXD + 2));
            pay = "";
            for (int k = 0; k < len; k++) begin
                int c = int'($urandom_range(0, cs.len() - 1));
                pay = {pay, cs.substr(c, c)};
            end
            model(tk, sid, pay, ul, exp, eck, efc, etr, en);
            stall = (en >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, en - 1)) : -1;
            if ($urandom_range(0, 1) == 0) repeat (10) @(negedge clk);
            run_frame($sformatf("rand%0d", r), tk, sid, pay, ul, stall, 1'b0, exp, eck, efc, etr, en);
        end

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
